// File: rtl/encoder_4to2.sv
// -----------------------------------------------------------------------------
// encoder_4to2
//   Registered 4-to-2 priority encoder with valid and multi-hot flags.
//   Converts four request lines into a binary index for downstream select/mux
//   logic. All outputs are flops; nothing passes combinationally from input
//   to output.
//
// Parameters
//   HIGH_PRIORITY : 1 = highest asserted index wins (A3 > A2 > A1 > A0)
//                   0 = lowest asserted index wins  (A0 > A1 > A2 > A3)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset (clears all outputs)
//   EN     in   1 = capture new encoding on this edge, 0 = hold
//   A0..A3 in   request lines, index 0..3
//   Y0,Y1  out  encoded index (registered)
//   VALID  out  at least one request was high at capture (registered)
//   MULTI  out  two or more requests were high at capture (registered)
// -----------------------------------------------------------------------------
module encoder_4to2 #(
  parameter int HIGH_PRIORITY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic EN,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  output logic Y0,
  output logic Y1,
  output logic VALID,
  output logic MULTI
);

  logic [3:0] req;
  logic [1:0] y_d, y_q;
  logic       valid_d, valid_q;
  logic       multi_d, multi_q;

  assign req = {A3, A2, A1, A0};

  // Index of the winning request. With no request the result is 00; VALID
  // is what tells that apart from an A0 request.
  function automatic logic [1:0] prio_idx(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    if (HIGH_PRIORITY != 0) begin
      if      (r[3]) idx = 2'd3;
      else if (r[2]) idx = 2'd2;
      else if (r[1]) idx = 2'd1;
      else           idx = 2'd0;
    end else begin
      if      (r[0]) idx = 2'd0;
      else if (r[1]) idx = 2'd1;
      else if (r[2]) idx = 2'd2;
      else if (r[3]) idx = 2'd3;
      else           idx = 2'd0;
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits
  // were set.
  function automatic logic is_multi(input logic [3:0] r);
    return (r & (r - 4'd1)) != 4'd0;
  endfunction

  always_comb begin
    y_d     = y_q;
    valid_d = valid_q;
    multi_d = multi_q;
    if (EN) begin
      y_d     = prio_idx(req);
      valid_d = |req;
      multi_d = is_multi(req);
    end
  end

  // Output register stage: reset takes precedence over EN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= 2'd0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign Y0    = y_q[0];
  assign Y1    = y_q[1];
  assign VALID = valid_q;
  assign MULTI = multi_q;

endmodule

// File: tb/tb_encoder_4to2.sv
// -----------------------------------------------------------------------------
// tb_encoder_4to2
//   Drives two encoder instances (HIGH_PRIORITY=1 and =0) from the same
//   inputs. Directed scenarios compare against literal expected codes; the
//   random scenario compares against a reference model that picks the winner
//   by scanning request indices and counts set bits.
//   Observed vector layout: {Y1, Y0, VALID, MULTI}.
// -----------------------------------------------------------------------------
module tb_encoder_4to2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] a;

  logic y0_h, y1_h, valid_h, multi_h;
  logic y0_l, y1_l, valid_l, multi_l;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  encoder_4to2 #(.HIGH_PRIORITY(1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .EN(en),
    .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]),
    .Y0(y0_h), .Y1(y1_h), .VALID(valid_h), .MULTI(multi_h)
  );

  encoder_4to2 #(.HIGH_PRIORITY(0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .EN(en),
    .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]),
    .Y0(y0_l), .Y1(y1_l), .VALID(valid_l), .MULTI(multi_l)
  );

  wire [3:0] obs_h = {y1_h, y0_h, valid_h, multi_h};
  wire [3:0] obs_l = {y1_l, y0_l, valid_l, multi_l};

  // Reference: winner index by scanning, flags by counting set bits.
  function automatic logic [3:0] ref_out(input logic [3:0] r, input bit hp);
    int cnt;
    int idx;
    cnt = 0;
    idx = 0;
    for (int i = 0; i < 4; i++) if (r[i]) cnt++;
    if (hp) begin
      for (int i = 0; i < 4; i++) if (r[i]) idx = i;
    end else begin
      for (int i = 3; i >= 0; i--) if (r[i]) idx = i;
    end
    return {idx[1:0], cnt >= 1, cnt >= 2};
  endfunction

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; a = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (obs_h !== 4'b0000) begin
        failures++;
        $display("FAIL reset_hi edge%0d got=%b want=0000", k, obs_h);
      end
      checks++;
      if (obs_l !== 4'b0000) begin
        failures++;
        $display("FAIL reset_lo edge%0d got=%b want=0000", k, obs_l);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_one_hot();
    logic [3:0] pats [4];
    logic [3:0] want [4];
    pats = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    want = '{4'b1110, 4'b1010, 4'b0110, 4'b0010};
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = pats[k];
      tick();
      checks++;
      if (obs_h !== want[k]) begin
        failures++;
        $display("FAIL onehot_hi in=%b got=%b want=%b", pats[k], obs_h, want[k]);
      end
      checks++;
      if (obs_l !== want[k]) begin
        failures++;
        $display("FAIL onehot_lo in=%b got=%b want=%b", pats[k], obs_l, want[k]);
      end
    end
  endtask

  task automatic test_all_zero();
    en = 1'b1; a = 4'b0000;
    tick();
    checks++;
    if (obs_h !== 4'b0000) begin
      failures++;
      $display("FAIL allzero_hi got=%b want=0000", obs_h);
    end
    checks++;
    if (obs_l !== 4'b0000) begin
      failures++;
      $display("FAIL allzero_lo got=%b want=0000", obs_l);
    end
  endtask

  task automatic test_priority();
    en = 1'b1; a = 4'b1010;
    tick();
    checks++;
    if (obs_h !== 4'b1111) begin
      failures++;
      $display("FAIL prio1010_hi got=%b want=1111", obs_h);
    end
    checks++;
    if (obs_l !== 4'b0111) begin
      failures++;
      $display("FAIL prio1010_lo got=%b want=0111", obs_l);
    end
    a = 4'b1111;
    tick();
    checks++;
    if (obs_h !== 4'b1111) begin
      failures++;
      $display("FAIL prio1111_hi got=%b want=1111", obs_h);
    end
    checks++;
    if (obs_l !== 4'b0011) begin
      failures++;
      $display("FAIL prio1111_lo got=%b want=0011", obs_l);
    end
  endtask

  task automatic test_enable_hold();
    en = 1'b1; a = 4'b0100;
    tick();
    checks++;
    if (obs_h !== 4'b1010) begin
      failures++;
      $display("FAIL hold_capture got=%b want=1010", obs_h);
    end
    en = 1'b0; a = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs_h !== 4'b1010) begin
        failures++;
        $display("FAIL hold_hi edge%0d got=%b want=1010", k, obs_h);
      end
      checks++;
      if (obs_l !== 4'b1010) begin
        failures++;
        $display("FAIL hold_lo edge%0d got=%b want=1010", k, obs_l);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (obs_h !== 4'b0010) begin
      failures++;
      $display("FAIL hold_release got=%b want=0010", obs_h);
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; a = 4'b1000;
    tick();
    checks++;
    if (obs_h !== 4'b1110) begin
      failures++;
      $display("FAIL midrst_pre got=%b want=1110", obs_h);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (obs_h !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_hi got=%b want=0000", obs_h);
    end
    checks++;
    if (obs_l !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_lo got=%b want=0000", obs_l);
    end
    rst_n = 1'b1; a = 4'b0010;
    tick();
    checks++;
    if (obs_h !== 4'b0110) begin
      failures++;
      $display("FAIL midrst_release got=%b want=0110", obs_h);
    end
  endtask

  // Random traffic with occasional resets and enable drops; the model keeps
  // the expected registered state for each instance.
  task automatic test_random();
    logic [3:0] exp_h, exp_l;
    exp_h = obs_h;  // model starts from the last directed expectation
    exp_l = obs_l;
    exp_h = 4'b0110;
    exp_l = 4'b0110;
    for (int k = 0; k < 300; k++) begin
      a     = 4'($urandom_range(0, 15));
      en    = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 15) != 0);
      if (!rst_n) begin
        exp_h = 4'b0000;
        exp_l = 4'b0000;
      end else if (en) begin
        exp_h = ref_out(a, 1'b1);
        exp_l = ref_out(a, 1'b0);
      end
      tick();
      checks++;
      if (obs_h !== exp_h) begin
        failures++;
        $display("FAIL rand_hi k=%0d in=%b en=%b rst_n=%b got=%b want=%b",
                 k, a, en, rst_n, obs_h, exp_h);
      end
      checks++;
      if (obs_l !== exp_l) begin
        failures++;
        $display("FAIL rand_lo k=%0d in=%b en=%b rst_n=%b got=%b want=%b",
                 k, a, en, rst_n, obs_l, exp_l);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    a     = 4'b0000;
    test_reset();
    test_one_hot();
    test_all_zero();
    test_priority();
    test_enable_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
